// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Holds the arbiter state encoding and per-requester bundle.
package dmem_arbiter_pkg;

  localparam int unsigned PKG_AW = 32;
  localparam int unsigned PKG_DW = 32;
  localparam int unsigned PKG_BW = PKG_DW / 8;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [PKG_AW-1:0] addr;
    logic [PKG_DW-1:0] wdata;
    logic [PKG_BW-1:0] be;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker.
// ptr_i names the port that wins a tie.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  // one-hot pick; a lone requester always wins
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port data memory between LSU (m0)
// and DMA/loader (m1) with round-robin and bounded lock.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [AWIDTH-1:0] m0_addr,
  input  logic [DWIDTH-1:0] m0_wdata,
  input  logic [DWIDTH/8-1:0] m0_be,
  input  logic              m0_lock,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [AWIDTH-1:0] m1_addr,
  input  logic [DWIDTH-1:0] m1_wdata,
  input  logic [DWIDTH/8-1:0] m1_be,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DWIDTH-1:0] m0_rdata,
  output logic [DWIDTH-1:0] m1_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_wen,
  output logic [DWIDTH/8-1:0] mem_wr_mask,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  mem_req_t rq0;
  mem_req_t rq1;
  mem_req_t sel;

  logic [1:0] req;
  logic [1:0] lock;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;

  arb_state_t    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          hold;
  logic          hk;

  logic [1:0]        rvalid_q;
  logic [DWIDTH-1:0] rdata0_q;
  logic [DWIDTH-1:0] rdata1_q;

  assign req  = {m1_req, m0_req};
  assign lock = {m1_lock, m0_lock};

  assign rq0 = '{
    we:    m0_we,
    addr:  PKG_AW'(m0_addr),
    wdata: PKG_DW'(m0_wdata),
    be:    PKG_BW'(m0_be)
  };

  assign rq1 = '{
    we:    m1_we,
    addr:  PKG_AW'(m1_addr),
    wdata: PKG_DW'(m1_wdata),
    be:    PKG_BW'(m1_be)
  };

  rr_arb2 u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt)
  );

  // lock holder keeps the port unless the other side
  // has waited out the full lock budget
  always_comb begin
    hold = 1'b0;
    hk   = 1'b0;
    unique case (state_q)
      LOCK0: begin
        hk   = 1'b0;
        hold = req[0] && lock[0] &&
               !(req[1] && cnt_q == CNT_MAX);
      end
      LOCK1: begin
        hk   = 1'b1;
        hold = req[1] && lock[1] &&
               !(req[0] && cnt_q == CNT_MAX);
      end
      default: begin
        hk   = 1'b0;
        hold = 1'b0;
      end
    endcase
  end

  // grant decision and next state; a broken lock
  // falls back to round-robin in the same cycle
  always_comb begin
    gnt     = 2'b00;
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (hold) begin
      gnt   = hk ? 2'b10 : 2'b01;
      ptr_d = ~hk;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      gnt     = rr_gnt;
      state_d = ARB;
      cnt_d   = '0;
      unique case (1'b1)
        gnt[0]: begin
          ptr_d = 1'b1;
          if (lock[0]) begin
            state_d = LOCK0;
            cnt_d   = CNT_ONE;
          end
        end
        gnt[1]: begin
          ptr_d = 1'b0;
          if (lock[1]) begin
            state_d = LOCK1;
            cnt_d   = CNT_ONE;
          end
        end
        default: ;
      endcase
    end
    if (!rst_n) begin
      gnt = 2'b00;
    end
  end

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // memory side follows the winner, idle is all-zero
  always_comb begin
    sel = '0;
    unique case (gnt)
      2'b01:   sel = rq0;
      2'b10:   sel = rq1;
      default: sel = '0;
    endcase
  end

  assign mem_addr    = AWIDTH'(sel.addr);
  assign mem_wdata   = DWIDTH'(sel.wdata);
  assign mem_wr_mask = (DWIDTH/8)'(sel.be);
  assign mem_wen     = sel.we;

  // arbiter state, rr pointer and lock counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // read return: one-cycle rvalid, data held until
  // the next read on the same port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q[0] <= gnt[0] & ~rq0.we;
      rvalid_q[1] <= gnt[1] & ~rq1.we;
      if (gnt[0] && !rq0.we) begin
        rdata0_q <= mem_rdata;
      end
      if (gnt[1] && !rq1.we) begin
        rdata1_q <= mem_rdata;
      end
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter.
// Directed plan steps followed by random traffic.
module tb_dmem_arbiter;

  localparam int MAXL = 8;

  logic clk;
  logic rst_n;

  logic        req   [2];
  logic        we    [2];
  logic        lock  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];

  logic        m0_gnt, m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wen;
  logic [3:0]  mem_wr_mask;

  logic [31:0] dmem [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256];

  int n_assert = 0;
  int n_fail   = 0;

  int          favour;
  int          holding;
  int          run;
  int          last_g;
  logic        exp_rv [2];
  logic [31:0] exp_rd [2];

  dmem_arbiter #(
    .AWIDTH   (32),
    .DWIDTH   (32),
    .MAX_LOCK (MAXL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req      (req[0]),
    .m0_we       (we[0]),
    .m0_addr     (addr[0]),
    .m0_wdata    (wdata[0]),
    .m0_be       (be[0]),
    .m0_lock     (lock[0]),
    .m1_req      (req[1]),
    .m1_we       (we[1]),
    .m1_addr     (addr[1]),
    .m1_wdata    (wdata[1]),
    .m1_be       (be[1]),
    .m1_lock     (lock[1]),
    .m0_gnt      (m0_gnt),
    .m1_gnt      (m1_gnt),
    .m0_rvalid   (m0_rvalid),
    .m1_rvalid   (m1_rvalid),
    .m0_rdata    (m0_rdata),
    .m1_rdata    (m1_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wen     (mem_wen),
    .mem_wr_mask (mem_wr_mask),
    .mem_rdata   (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = dmem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_wen) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wr_mask[b]) begin
          dmem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) begin
      req[p]   = 1'b0;
      we[p]    = 1'b0;
      lock[p]  = 1'b0;
      addr[p]  = 32'h0;
      wdata[p] = 32'h0;
      be[p]    = 4'h0;
    end
  endtask

  task automatic model_reset();
    favour  = 0;
    holding = -1;
    run     = 0;
    last_g  = -1;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
  endtask

  // who should win this cycle, from the arbitration rules
  function automatic int pick();
    int k;
    int o;
    if (holding >= 0) begin
      k = holding;
      o = 1 - k;
      if (req[k] && lock[k] && !(req[o] && run >= MAXL))
        return k;
    end
    if (req[0] && req[1]) return favour;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  // one clock: check at negedge, advance model at posedge
  task automatic step();
    int          g;
    int          o;
    int          idx;
    logic        ew;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [3:0]  em;
    @(negedge clk);
    g = pick();
    ew = 1'b0; ea = 32'h0; ed = 32'h0; em = 4'h0;
    if (g >= 0) begin
      ew = we[g]; ea = addr[g]; ed = wdata[g]; em = be[g];
    end
    chk("m0_gnt", 32'(m0_gnt), 32'(g == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(g == 1));
    chk("mem_wen", 32'(mem_wen), 32'(ew));
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("mem_wr_mask", 32'(mem_wr_mask), 32'(em));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv[0]));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv[1]));
    chk("m0_rdata", m0_rdata, exp_rd[0]);
    chk("m1_rdata", m1_rdata, exp_rd[1]);
    last_g = g;
    @(posedge clk);
    if (g >= 0) begin
      o   = 1 - g;
      idx = int'(addr[g][9:2]);
      if (we[g]) begin
        for (int b = 0; b < 4; b++)
          if (be[g][b])
            ref_mem[idx][8*b +: 8] = wdata[g][8*b +: 8];
        exp_rv[g] = 1'b0;
      end else begin
        exp_rv[g] = 1'b1;
        exp_rd[g] = ref_mem[idx];
      end
      exp_rv[o] = 1'b0;
      favour = o;
      if (lock[g]) begin
        if (holding == g) run++;
        else begin
          holding = g;
          run     = 1;
        end
      end else begin
        holding = -1;
      end
    end else begin
      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
      holding   = -1;
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    req[0] = 1'b1;
    req[1] = 1'b1;
    we[0]  = 1'b1;
    be[0]  = 4'hF;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'h0);
    chk("rst_mem_wen", 32'(mem_wen), 32'h0);
    chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int seen;
    int wpos;
    int i;
    logic [31:0] w;
    for (int j = 0; j < 256; j++) ref_mem[j] = 32'h0;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #12;

    // m0 alone: write then read back
    do_reset();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10;
    wdata[0] = 32'hDEADBEEF; be[0] = 4'hF;
    step();
    chk("m0_wr_gnt", 32'(last_g), 32'h0);
    we[0] = 1'b0; wdata[0] = 32'h0;
    step();
    chk("m0_rd_gnt", 32'(last_g), 32'h0);
    idle_inputs();
    chk("m0_rd_rvalid", 32'(m0_rvalid), 32'h1);
    chk("m0_rd_data", m0_rdata, 32'hDEADBEEF);
    step();
    chk("m0_rvalid_drop", 32'(m0_rvalid), 32'h0);

    // contention without lock alternates from m0
    do_reset();
    req[0] = 1'b1; addr[0] = 32'h10;
    req[1] = 1'b1; addr[1] = 32'h10;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("contention_order", 32'(last_g), 32'(j % 2));
    end
    idle_inputs();
    step();

    // m1 locked burst while m0 waits
    do_reset();
    req[1] = 1'b1; we[1] = 1'b1; lock[1] = 1'b1;
    be[1] = 4'hF;
    for (int j = 0; j < 4; j++) begin
      addr[1]  = 32'h100 + 32'(4 * j);
      wdata[1] = 32'hC0DE0000 + 32'(j);
      step();
      chk("burst_m1_gnt", 32'(last_g), 32'h1);
      req[0] = 1'b1; addr[0] = 32'h0;
    end
    req[1] = 1'b0; lock[1] = 1'b0;
    step();
    chk("burst_then_m0", 32'(last_g), 32'h0);
    idle_inputs();
    step();
    for (int j = 0; j < 4; j++)
      chk("burst_mem", dmem[64 + j], 32'hC0DE0000 + 32'(j));

    // lock cannot starve the other port
    do_reset();
    req[1] = 1'b1; we[1] = 1'b1; lock[1] = 1'b1;
    be[1] = 4'h3; addr[1] = 32'h40; wdata[1] = 32'h1234;
    seen = 0;
    wpos = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (j == 0) begin
        chk("starve_first_m1", 32'(last_g), 32'h1);
        req[0] = 1'b1; addr[0] = 32'h44;
      end
      if (last_g == 0 && seen == 0) begin
        seen   = 1;
        wpos   = j + 1;
        req[0] = 1'b0;
      end
    end
    chk("starve_m0_seen", 32'(seen), 32'h1);
    chk("starve_bound", 32'(wpos <= MAXL + 1), 32'h1);
    idle_inputs();
    step();

    // byte-masked write then full read
    do_reset();
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20;
    wdata[1] = 32'hAABBCCDD; be[1] = 4'hF;
    step();
    wdata[1] = 32'h00000011; be[1] = 4'b0001;
    step();
    idle_inputs();
    req[0] = 1'b1; addr[0] = 32'h20;
    step();
    idle_inputs();
    chk("mask_rdata", m0_rdata, 32'hAABBCC11);

    // reset lands while read data is being returned
    req[0] = 1'b1; addr[0] = 32'h10;
    step();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(m0_rvalid), 32'h0);
    chk("midrst_rdata", m0_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int j = 0; j < 3; j++) step();

    // random traffic against the model
    do_reset();
    i = 0;
    while (i < 400) begin
      for (int p = 0; p < 2; p++) begin
        if (!(req[p] && last_g != p && $urandom_range(0, 3) != 0)) begin
          req[p]   = ($urandom_range(0, 2) != 0);
          we[p]    = $urandom_range(0, 1) == 1;
          lock[p]  = $urandom_range(0, 1) == 1;
          w        = 32'($urandom_range(0, 63));
          addr[p]  = w << 2;
          wdata[p] = $urandom;
          be[p]    = 4'($urandom_range(0, 15));
        end
      end
      step();
      i++;
    end
    idle_inputs();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
